// File: rtl/firmware_loader_rom_if.sv
//------------------------------------------------------------------------------
// firmware_loader_rom_if
// Load-stream and CPU read bundle for the firmware_loader_rom block.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface firmware_loader_rom_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              load_start;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic              loading;
    logic              done;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_select;
    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] checksum;

    // Host/CPU side
    modport master (
        output load_start, load_data, load_valid, cpu_address, cpu_select,
        input  load_ready, loading, done, cpu_data, checksum
    );

    // ROM side
    modport slave (
        input  load_start, load_data, load_valid, cpu_address, cpu_select,
        output load_ready, loading, done, cpu_data, checksum
    );
endinterface

`default_nettype wire

// File: rtl/firmware_loader_rom.sv
//------------------------------------------------------------------------------
// firmware_loader_rom
// Streamed-load firmware memory with 1-cycle registered CPU reads.
// Optional macro: FIRMWARE_LOADER_ROM_CHECKSUM_EN builds the load checksum.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module firmware_loader_rom #(
    parameter int                ADDR_W     = 14,
    parameter int                DATA_W     = 8,
    parameter int                LOAD_BYTES = 16384,
    parameter logic [DATA_W-1:0] ERASED_VAL = 8'hFF
) (
    input  wire logic            clk,
    input  wire logic            rst,
    firmware_loader_rom_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [ADDR_W:0] c_LOAD_BYTES = (ADDR_W+1)'(LOAD_BYTES);
    localparam logic [ADDR_W:0] c_LOAD_LAST  = (ADDR_W+1)'(LOAD_BYTES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [ADDR_W:0]   r_ptr;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_cpu_data;
    logic              w_xfer;
    logic              w_restart;
    logic              w_last;
    logic              w_in_range;

    assign w_xfer     = (r_state == S_LOAD) && bus.load_valid;
    assign w_last     = (r_ptr == c_LOAD_LAST);
    // load_start only acts outside LOAD; reload from RUN restarts at address 0
    assign w_restart  = bus.load_start && (r_state != S_LOAD);
    assign w_in_range = ({1'b0, bus.cpu_address} < c_LOAD_BYTES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.load_start)   w_state_next = S_LOAD;
            S_LOAD:  if (w_xfer && w_last) w_state_next = S_RUN;
            S_RUN:   if (bus.load_start)   w_state_next = S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready = 1'b0;
        bus.loading    = 1'b0;
        bus.done       = 1'b0;
        case (r_state)
            S_LOAD: begin
                bus.load_ready = 1'b1;
                bus.loading    = 1'b1;
            end
            S_RUN:   bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_restart) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[r_ptr[ADDR_W-1:0]] <= bus.load_data;
        end
    end

    // A read issued on the cycle that starts a reload would land in LOAD, so it is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_data <= '0;
        end else if ((r_state == S_RUN) && bus.cpu_select && !bus.load_start) begin
            r_cpu_data <= w_in_range ? r_mem[bus.cpu_address] : ERASED_VAL;
        end else begin
            r_cpu_data <= '0;
        end
    end

    assign bus.cpu_data = r_cpu_data;

`ifdef FIRMWARE_LOADER_ROM_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_restart) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + bus.load_data;
        end
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_firmware_loader_rom.sv
//------------------------------------------------------------------------------
// tb_firmware_loader_rom
// Directed self-checking bench for firmware_loader_rom (LOAD_BYTES=64).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_firmware_loader_rom;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 8;
    localparam int LOAD_BYTES = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    firmware_loader_rom_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    firmware_loader_rom #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LOAD_BYTES (LOAD_BYTES),
        .ERASED_VAL (8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        logic [7:0] b;
        b = 8'(i);
        case (kind)
            0:       return 8'hA0 ^ b;
            1:       return 8'(i * 7 + 3);
            2:       return 8'h3C ^ b;
            default: return ~b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Streams an image; stop_after aborts after that many transfers, pulse_at
    // raises load_start alongside that transfer index.
    task automatic do_load(input int kind, input bit gapped, input int stop_after,
                           input int pulse_at);
        int n;
        int cyc;
        bit v;
        logic [7:0] sum;
        n = 0; cyc = 0; sum = 8'h00;
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        chk("load_entry_loading", {31'd0, bus.loading}, 32'd1);
        chk("load_entry_ready", {31'd0, bus.load_ready}, 32'd1);
        chk("load_entry_done", {31'd0, bus.done}, 32'd0);
        while (n < LOAD_BYTES && n != stop_after) begin
            v = gapped ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            bus.load_valid = v;
            bus.load_data  = v ? pat(kind, n) : 8'hEE;
            bus.load_start = v && (n == pulse_at);
            step();
            cyc++;
            bus.load_start = 1'b0;
            if (v) begin
                sum = sum + pat(kind, n);
                n++;
            end
            if (n < LOAD_BYTES) begin
                chk("load_done_low", {31'd0, bus.done}, 32'd0);
                chk("load_cpu_zero", {24'd0, bus.cpu_data}, 32'd0);
            end
        end
        bus.load_valid = 1'b0;
        if (n == LOAD_BYTES) begin
            chk("done_rise", {31'd0, bus.done}, 32'd1);
            chk("ready_drop", {31'd0, bus.load_ready}, 32'd0);
            chk("loading_drop", {31'd0, bus.loading}, 32'd0);
`ifdef FIRMWARE_LOADER_ROM_CHECKSUM_EN
            chk("checksum", {24'd0, bus.checksum}, {24'd0, sum});
`else
            chk("checksum", {24'd0, bus.checksum}, 32'd0);
`endif
        end
    endtask

    task automatic read_all(input int kind);
        for (int a = 0; a < LOAD_BYTES; a++) begin
            bus.cpu_select  = 1'b1;
            bus.cpu_address = 14'(a);
            step();
            chk("read_data", {24'd0, bus.cpu_data}, {24'd0, pat(kind, a)});
        end
        bus.cpu_address = 14'd64;
        step();
        chk("read_erased_64", {24'd0, bus.cpu_data}, 32'hFF);
        bus.cpu_address = 14'd16383;
        step();
        chk("read_erased_top", {24'd0, bus.cpu_data}, 32'hFF);
        bus.cpu_select  = 1'b0;
        bus.cpu_address = 14'd0;
        step();
        chk("read_unselected", {24'd0, bus.cpu_data}, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = 8'h00;
        bus.cpu_select = 1'b1; bus.cpu_address = 14'd0;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_ready", {31'd0, bus.load_ready}, 32'd0);
            chk("idle_loading", {31'd0, bus.loading}, 32'd0);
            chk("idle_done", {31'd0, bus.done}, 32'd0);
            chk("idle_cpu_data", {24'd0, bus.cpu_data}, 32'd0);
        end
        chk("idle_checksum", {24'd0, bus.checksum}, 32'd0);
        bus.cpu_select = 1'b0;
    endtask

    task automatic test_full_load();
        do_load(0, 1'b0, -1, -1);
        read_all(0);
    endtask

    task automatic test_gapped_load();
        do_load(1, 1'b1, -1, -1);
        read_all(1);
    endtask

    task automatic test_reset_mid_load();
        do_load(3, 1'b0, 20, -1);
        rst = 1'b1;
        bus.cpu_select = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_loading", {31'd0, bus.loading}, 32'd0);
        step();
        chk("rst_cpu_data", {24'd0, bus.cpu_data}, 32'd0);
        chk("rst_still_idle", {31'd0, bus.loading}, 32'd0);
        bus.cpu_select = 1'b0;
        do_load(2, 1'b0, -1, -1);
        read_all(2);
    endtask

    task automatic test_reload_ignore_pulse();
        do_load(3, 1'b0, -1, 10);
        read_all(3);
    endtask

    initial begin
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = 8'h00;
        bus.cpu_select = 1'b0; bus.cpu_address = '0;
        test_reset();
        test_full_load();
        test_gapped_load();
        test_reset_mid_load();
        test_reload_ignore_pulse();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
